// File: rtl/i2cdefs.sv
// Shared I2C definitions: responder state encodings, ACK/NACK levels and the
// default device address. Also used by the master-side generator.
package i2cdefs;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
  } i2c_state_e;

  localparam logic       I2C_ACK      = 1'b0;
  localparam logic       I2C_NACK     = 1'b1;
  localparam logic       I2C_WRITE    = 1'b0;
  localparam logic [6:0] I2C_DEF_ADDR = 7'h1a;
endpackage

// File: rtl/i2cbusmonitor.sv
// Synchronises sck/sda and produces registered edge and START/STOP flags,
// 3 clk after the pin edge. Only a stable-high sck qualifies START/STOP.
module i2cbusmonitor (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic sda,
  output logic sck_rise,
  output logic sck_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);
  // [0],[1] synchroniser, [2] history
  logic [2:0] sck_q, sda_q;
  logic       rise_d, fall_d, start_d, stop_d, sda_d;
  logic       rise_q, fall_q, start_q, stop_q, sdas_q;
  logic       sck_hi;

  always_comb begin
    sck_hi  = sck_q[1] & sck_q[2];
    rise_d  = sck_q[1] & ~sck_q[2];
    fall_d  = ~sck_q[1] & sck_q[2];
    start_d = sck_hi & ~sda_q[1] & sda_q[2];
    stop_d  = sck_hi & sda_q[1] & ~sda_q[2];
    sda_d   = sda_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q   <= 3'b111;
      sda_q   <= 3'b111;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      sdas_q  <= 1'b1;
    end else begin
      sck_q   <= {sck_q[1:0], sck};
      sda_q   <= {sda_q[1:0], sda};
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      sdas_q  <= sda_d;
    end
  end

  assign sck_rise = rise_q;
  assign sck_fall = fall_q;
  assign start    = start_q;
  assign stop     = stop_q;
  assign sda_s    = sdas_q;
endmodule

// File: rtl/i2cslavereceive.sv
// Write-only I2C responder: matches ADDRESS, ACKs address/register/data bytes
// and emits each completed register write as a one-cycle strobe.
module i2cslavereceive
  import i2cdefs::*;
#(
  parameter logic [6:0] ADDRESS = I2C_DEF_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  inout  wire        sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  logic sck_rise, sck_fall, start, stop, sda_s;

  i2cbusmonitor u_mon (
    .clk      (clk),
    .rst_n    (reset),
    .sck      (sck),
    .sda      (sda),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, reg_q, reg_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic       sda_low_q, sda_low_d, busy_q, busy_d, wr_valid_q, wr_valid_d;
  logic [7:0] byte_in;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    reg_d      = reg_q;
    sda_low_d  = sda_low_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    byte_in    = {sh_q[6:0], sda_s};

    if (start) begin
      state_d   = ST_ADDR;
      cnt_d     = 3'd0;
      sh_d      = 8'h00;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (stop) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_DATA: begin
          if (sck_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                if (byte_in[7:1] == ADDRESS && byte_in[0] == I2C_WRITE) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_REG) begin
                reg_d   = byte_in;
                state_d = ST_REG_ACK;
              end else begin
                state_d = ST_DATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
          // First fall after bit 8 pulls sda low, the fall after the 9th clock releases it
          if (sck_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              case (state_q)
                ST_ADDR_ACK: state_d = ST_REG;
                ST_REG_ACK:  state_d = ST_DATA;
                default: begin
                  state_d    = ST_IGNORE;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = reg_q;
                  wr_data_d  = sh_q;
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      sh_q       <= 8'h00;
      reg_q      <= 8'h00;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      reg_q      <= reg_d;
      sda_low_q  <= sda_low_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign sda      = sda_low_q ? I2C_ACK : 1'bz;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_i2cslavereceive.sv
// Bench: a bit-banged I2C master drives directed writes; expected strobes are
// queued at issue time and a monitor pops/compares them on each wr_valid.
module tb_i2cslavereceive;
  localparam time Q = 100ns;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sck = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       wr_valid, busy;
  logic [7:0] wr_addr, wr_data;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic        vld_prev = 1'b0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2cslavereceive #(.ADDRESS(7'h1a)) dut (
    .clk      (clk),
    .reset    (reset),
    .sck      (sck),
    .sda      (sda),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (wr_valid) begin
      n_chk++;
      if (vld_prev) begin
        n_fail++;
        $display("FAIL strobe_width: got 2+ cycles want 1");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got %h/%h want none", wr_addr, wr_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL strobe_value: got %h/%h want %h/%h", wr_addr, wr_data, e[15:8], e[7:0]);
        end
      end
    end
    vld_prev <= wr_valid;
  end

  task automatic i2c_start();
    m_low = 1'b0; #Q;
    sck = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    sck = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    sck = 1'b1;   #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; #Q;
      sck = 1'b1;    #(2*Q);
      sck = 1'b0;    #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    send_bits(b);
    m_low = 1'b0; #Q;
    sck = 1'b1;   #Q;
    chk(nm, {7'd0, sda}, exp_ack ? 8'h00 : 8'h01);
    #Q;
    sck = 1'b0;   #Q;
  endtask

  task automatic wr(input logic [7:0] r, input logic [7:0] d);
    exp_q.push_back({r, d});
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr");
    send_byte(r, 1'b1, "ack_reg");
    send_byte(d, 1'b1, "ack_data");
    i2c_stop();
  endtask

  initial begin
    #25;
    chk("rst_sda", {7'd0, sda}, 8'h01);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_valid", {7'd0, wr_valid}, 8'h00);
    chk("rst_addr", wr_addr, 8'h00);
    chk("rst_data", wr_data, 8'h00);
    reset = 1'b1;
    #Q;

    // basic write, busy high until STOP
    exp_q.push_back(16'h05AA);
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr");
    send_byte(8'h05, 1'b1, "ack_reg");
    chk("busy_mid", {7'd0, busy}, 8'h01);
    send_byte(8'hAA, 1'b1, "ack_data");
    i2c_stop();
    #Q;
    chk("busy_after_stop", {7'd0, busy}, 8'h00);

    // init sequence
    wr(8'h01, 8'h12);
    wr(8'h02, 8'h55);
    wr(8'h00, 8'hDE);

    // wrong address, then read bit set
    i2c_start();
    send_byte(8'h36, 1'b0, "nack_addr_1b");
    chk("busy_mismatch", {7'd0, busy}, 8'h00);
    i2c_stop();
    i2c_start();
    send_byte(8'h35, 1'b0, "nack_read");
    chk("busy_read", {7'd0, busy}, 8'h00);
    i2c_stop();

    // partial: no strobe, outputs hold
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr_part");
    send_byte(8'h05, 1'b1, "ack_reg_part");
    i2c_stop();
    #Q;
    chk("hold_addr", wr_addr, 8'h00);
    chk("hold_data", wr_data, 8'hDE);

    // repeated start aborts, then full write
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr_rs");
    send_byte(8'h07, 1'b1, "ack_reg_rs");
    exp_q.push_back(16'h0255);
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr_rs2");
    send_byte(8'h02, 1'b1, "ack_reg_rs2");
    send_byte(8'h55, 1'b1, "ack_data_rs2");
    i2c_stop();

    // third byte NACKed
    exp_q.push_back(16'h00DE);
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr_3b");
    send_byte(8'h00, 1'b1, "ack_reg_3b");
    send_byte(8'hDE, 1'b1, "ack_data_3b");
    send_byte(8'h77, 1'b0, "nack_third");
    i2c_stop();

    // reset while ACK is driven
    i2c_start();
    send_bits(8'h34);
    m_low = 1'b0; #Q;
    sck = 1'b1;   #Q;
    chk("ack_before_reset", {7'd0, sda}, 8'h00);
    reset = 1'b0;
    #1;
    chk("reset_sda_release", {7'd0, sda}, 8'h01);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    chk("reset_valid", {7'd0, wr_valid}, 8'h00);
    chk("reset_addr", wr_addr, 8'h00);
    chk("reset_data", wr_data, 8'h00);
    #Q;
    reset = 1'b1;
    #Q;
    sck = 1'b0; #Q;
    i2c_stop();
    wr(8'h05, 8'hAA);

    #(10*Q);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_strobes: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
